// File: rtl/pc_event_sequencer.sv
// pc_event_sequencer
// Program counter with prioritised, nestable event dispatch for the calculator
// CPU. Event lines are edge-detected into pending bits. Fixed priority picks a
// pending channel (channel 0 highest) and jumps to that channel's vector. The
// interrupted return address and channel are pushed on a small return stack,
// and RETI pops them back.
module pc_event_sequencer #(
  parameter int unsigned    AW          = 8,
  parameter int unsigned    NCH         = 4,
  parameter int unsigned    STACK_DEPTH = 4,
  parameter logic [AW-1:0]  RESET_ADDR  = '0,
  localparam int unsigned   CW          = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned   DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic              ck_i,
  input  logic              rst_n_i,
  input  logic              ld_i,
  input  logic [AW-1:0]     adr_i,
  input  logic [NCH-1:0]    event_i,
  input  logic [NCH*AW-1:0] vec_i,
  input  logic              ien_i,
  input  logic              reti_i,
  output logic [AW-1:0]     ad_o,
  output logic [NCH-1:0]    irq_ack_o,
  output logic              in_isr_o,
  output logic [CW-1:0]     act_ch_o,
  output logic [NCH-1:0]    pend_o,
  output logic              stk_err_o
);

  // Architectural state.
  logic [AW-1:0]  ad_q, ad_d;
  logic [NCH-1:0] event_q;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] irq_ack_q, irq_ack_d;
  logic [DW-1:0]  depth_q, depth_d;
  logic           stk_err_q, stk_err_d;
  logic           in_isr_q, in_isr_d;

  // Return stack. Entry 0 is always the innermost frame. Entries at or above
  // the current depth are kept at zero, so stk_ch_q[0] reads 0 when the stack
  // is empty.
  logic [AW-1:0]  stk_addr_q [STACK_DEPTH];
  logic [AW-1:0]  stk_addr_d [STACK_DEPTH];
  logic [CW-1:0]  stk_ch_q   [STACK_DEPTH];
  logic [CW-1:0]  stk_ch_d   [STACK_DEPTH];

  // Decode signals.
  logic [NCH-1:0] rise_s;
  logic [AW-1:0]  nxt_s;
  logic           cand_found_s;
  logic [CW-1:0]  sel_ch_s;
  logic [AW-1:0]  sel_vec_s;
  logic [NCH-1:0] sel_onehot_s;
  logic           pop_s;
  logic           reti_err_s;
  logic           preempt_ok_s;
  logic           room_s;
  logic           dispatch_s;

  assign rise_s       = event_i & ~event_q;
  assign nxt_s        = ld_i ? adr_i : (ad_q + {{(AW-1){1'b0}}, 1'b1});
  assign pop_s        = reti_i && (depth_q != {DW{1'b0}});
  assign reti_err_s   = reti_i && (depth_q == {DW{1'b0}});
  assign room_s       = (depth_q < DW'(STACK_DEPTH));
  assign preempt_ok_s = (depth_q == {DW{1'b0}}) || (sel_ch_s < stk_ch_q[0]);
  assign dispatch_s   = !pop_s && ien_i && room_s && cand_found_s && preempt_ok_s;

  // Priority pick: lowest-index pending channel whose vector is non-zero.
  always_comb begin
    cand_found_s = 1'b0;
    sel_ch_s     = {CW{1'b0}};
    sel_vec_s    = {AW{1'b0}};
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_q[i] && (vec_i[i*AW +: AW] != {AW{1'b0}})) begin
        cand_found_s = 1'b1;
        sel_ch_s     = CW'(i);
        sel_vec_s    = vec_i[i*AW +: AW];
      end else begin
        cand_found_s = cand_found_s;
      end
    end
  end

  // One-hot form of the selected channel, used for the ack pulse and the pending clear.
  always_comb begin
    sel_onehot_s = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      sel_onehot_s[i] = (sel_ch_s == CW'(i));
    end
  end

  // Next address, pending, ack and depth: a return beats a dispatch, which beats sequential flow.
  always_comb begin
    ad_d      = nxt_s;
    irq_ack_d = {NCH{1'b0}};
    depth_d   = depth_q;
    stk_err_d = stk_err_q | reti_err_s;
    if (pop_s) begin
      ad_d    = stk_addr_q[0];
      depth_d = depth_q - {{(DW-1){1'b0}}, 1'b1};
    end else if (dispatch_s) begin
      ad_d      = sel_vec_s;
      irq_ack_d = sel_onehot_s;
      depth_d   = depth_q + {{(DW-1){1'b0}}, 1'b1};
    end else begin
      ad_d = nxt_s;
    end
    // A new edge wins over a dispatch clear of the same channel.
    pend_d   = (pend_q & ~irq_ack_d) | rise_s;
    in_isr_d = (depth_d != {DW{1'b0}});
  end

  // Return stack: shift down on pop, shift up and insert on dispatch.
  always_comb begin
    for (int k = 0; k < STACK_DEPTH; k++) begin
      stk_addr_d[k] = stk_addr_q[k];
      stk_ch_d[k]   = stk_ch_q[k];
    end
    if (pop_s) begin
      for (int k = 0; k < STACK_DEPTH - 1; k++) begin
        stk_addr_d[k] = stk_addr_q[k+1];
        stk_ch_d[k]   = stk_ch_q[k+1];
      end
      stk_addr_d[STACK_DEPTH-1] = {AW{1'b0}};
      stk_ch_d[STACK_DEPTH-1]   = {CW{1'b0}};
    end else if (dispatch_s) begin
      for (int k = STACK_DEPTH - 1; k > 0; k--) begin
        stk_addr_d[k] = stk_addr_q[k-1];
        stk_ch_d[k]   = stk_ch_q[k-1];
      end
      stk_addr_d[0] = nxt_s;
      stk_ch_d[0]   = sel_ch_s;
    end else begin
      stk_addr_d[0] = stk_addr_q[0];
    end
  end

  // State registers. Reset captures the live event lines so that levels already high do not fire.
  always_ff @(posedge ck_i) begin
    if (!rst_n_i) begin
      ad_q      <= RESET_ADDR;
      event_q   <= event_i;
      pend_q    <= {NCH{1'b0}};
      irq_ack_q <= {NCH{1'b0}};
      depth_q   <= {DW{1'b0}};
      stk_err_q <= 1'b0;
      in_isr_q  <= 1'b0;
      for (int k = 0; k < STACK_DEPTH; k++) begin
        stk_addr_q[k] <= {AW{1'b0}};
        stk_ch_q[k]   <= {CW{1'b0}};
      end
    end else begin
      ad_q      <= ad_d;
      event_q   <= event_i;
      pend_q    <= pend_d;
      irq_ack_q <= irq_ack_d;
      depth_q   <= depth_d;
      stk_err_q <= stk_err_d;
      in_isr_q  <= in_isr_d;
      for (int k = 0; k < STACK_DEPTH; k++) begin
        stk_addr_q[k] <= stk_addr_d[k];
        stk_ch_q[k]   <= stk_ch_d[k];
      end
    end
  end

  assign ad_o      = ad_q;
  assign irq_ack_o = irq_ack_q;
  assign in_isr_o  = in_isr_q;
  assign act_ch_o  = stk_ch_q[0];
  assign pend_o    = pend_q;
  assign stk_err_o = stk_err_q;

endmodule

// File: tb/tb_pc_event_sequencer.sv
// Bench for pc_event_sequencer: two instances (stack depth 4 and 1) share the
// same stimulus. Directed scenarios use hand-derived values. A randomized run
// compares both instances every cycle against a queue-style reference model.
module tb_pc_event_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ld, ien, reti;
  logic [7:0] adr;
  logic [3:0] ev;
  logic [7:0] vecs [4];
  logic [31:0] vec_bus;
  assign vec_bus = {vecs[3], vecs[2], vecs[1], vecs[0]};

  logic [7:0] ad_a, ad_b;
  logic [3:0] ack_a, ack_b, pend_a, pend_b;
  logic       isr_a, isr_b, err_a, err_b;
  logic [1:0] act_a, act_b;

  int checks = 0;
  int passed = 0;

  pc_event_sequencer #(.AW(8), .NCH(4), .STACK_DEPTH(4), .RESET_ADDR(8'h00)) dut_a (
    .ck_i(clk), .rst_n_i(rst_n), .ld_i(ld), .adr_i(adr), .event_i(ev), .vec_i(vec_bus),
    .ien_i(ien), .reti_i(reti), .ad_o(ad_a), .irq_ack_o(ack_a), .in_isr_o(isr_a),
    .act_ch_o(act_a), .pend_o(pend_a), .stk_err_o(err_a));

  pc_event_sequencer #(.AW(8), .NCH(4), .STACK_DEPTH(1), .RESET_ADDR(8'h00)) dut_b (
    .ck_i(clk), .rst_n_i(rst_n), .ld_i(ld), .adr_i(adr), .event_i(ev), .vec_i(vec_bus),
    .ien_i(ien), .reti_i(reti), .ad_o(ad_b), .irq_ack_o(ack_b), .in_isr_o(isr_b),
    .act_ch_o(act_b), .pend_o(pend_b), .stk_err_o(err_b));

  // Reference model state, index m selects the instance (0: depth 4, 1: depth 1).
  logic [7:0] m_ad   [2];
  logic [3:0] m_pend [2];
  logic [3:0] m_evq  [2];
  logic [3:0] m_ack  [2];
  logic       m_err  [2];
  int         m_depth[2];
  int         m_lim  [2];
  logic [7:0] m_sa   [2][4];
  logic [1:0] m_sc   [2][4];

  task automatic model_step(input int m);
    logic [3:0] rise;
    logic [7:0] nxt;
    int         sel;
    bit         disp;
    if (!rst_n) begin
      m_ad[m] = 8'h00; m_pend[m] = 4'h0; m_ack[m] = 4'h0; m_err[m] = 1'b0;
      m_depth[m] = 0; m_evq[m] = ev;
    end else begin
      rise = ev & ~m_evq[m];
      m_ack[m] = 4'h0;
      nxt = ld ? adr : m_ad[m] + 8'd1;
      if (reti && m_depth[m] > 0) begin
        m_depth[m] = m_depth[m] - 1;
        m_ad[m] = m_sa[m][m_depth[m]];
      end else begin
        if (reti) m_err[m] = 1'b1;
        sel = -1;
        for (int i = 0; i < 4; i++)
          if (sel < 0 && m_pend[m][i] && vecs[i] != 8'h00) sel = i;
        disp = ien && (m_depth[m] < m_lim[m]) && (sel >= 0);
        if (disp && m_depth[m] > 0) disp = (sel < int'(m_sc[m][m_depth[m]-1]));
        if (disp) begin
          m_sa[m][m_depth[m]] = nxt;
          m_sc[m][m_depth[m]] = 2'(sel);
          m_depth[m] = m_depth[m] + 1;
          m_ad[m] = vecs[sel];
          m_pend[m][sel] = 1'b0;
          m_ack[m][sel] = 1'b1;
        end else begin
          m_ad[m] = nxt;
        end
      end
      m_pend[m] = m_pend[m] | rise;
      m_evq[m] = ev;
    end
  endtask

  function automatic logic [19:0] expv(input int m);
    logic [1:0] a;
    if (m_depth[m] > 0) a = m_sc[m][m_depth[m]-1];
    else a = 2'd0;
    return {m_ad[m], m_ack[m], (m_depth[m] > 0), a, m_pend[m], m_err[m]};
  endfunction

  function automatic logic [19:0] obs(input int m);
    if (m == 0) return {ad_a, ack_a, isr_a, act_a, pend_a, err_a};
    return {ad_b, ack_b, isr_b, act_b, pend_b, err_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic set_vecs(input logic [7:0] v0, v1, v2, v3);
    vecs[0] = v0; vecs[1] = v1; vecs[2] = v2; vecs[3] = v3;
  endtask

  task automatic test_reset();
    ev = 4'h0; ld = 1'b0; reti = 1'b0; ien = 1'b0; set_vecs(8'h00, 8'h00, 8'h00, 8'h00);
    do_reset(2);
    checks++;
    if (obs(0) !== 20'h00000) $display("FAIL reset_a got %h exp %h", obs(0), 20'h00000);
    else passed++;
    checks++;
    if (obs(1) !== 20'h00000) $display("FAIL reset_b got %h exp %h", obs(1), 20'h00000);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    ev = 4'h0; ien = 1'b1; set_vecs(8'h00, 8'h00, 8'h00, 8'h00);
    do_reset(1);
    for (int k = 1; k <= 256; k++) begin
      tick();
      e = 8'(k);
      checks++;
      if (ad_a !== e || ad_b !== e || ack_a !== 4'h0 || ack_b !== 4'h0)
        $display("FAIL wrap k=%0d got ad %h/%h ack %h/%h exp ad %h ack 0", k, ad_a, ad_b, ack_a, ack_b, e);
      else passed++;
    end
  endtask

  task automatic test_dispatch();
    ev = 4'h0; ien = 1'b1; set_vecs(8'h40, 8'h00, 8'h00, 8'h00);
    do_reset(1);
    repeat (5) tick();
    ev = 4'b0001; tick();
    checks++;
    if (ad_a !== 8'h06 || pend_a !== 4'b0001 || ack_a !== 4'h0)
      $display("FAIL disp_pend got ad %h pend %b ack %b exp 06 0001 0000", ad_a, pend_a, ack_a);
    else passed++;
    tick();
    checks++;
    if (ad_a !== 8'h40 || ack_a !== 4'b0001 || isr_a !== 1'b1 || pend_a !== 4'h0 || act_a !== 2'd0)
      $display("FAIL disp_vec got ad %h ack %b isr %b pend %b exp 40 0001 1 0000", ad_a, ack_a, isr_a, pend_a);
    else passed++;
    tick();
    checks++;
    if (ad_a !== 8'h41 || ack_a !== 4'h0)
      $display("FAIL disp_ackpulse got ad %h ack %b exp 41 0000", ad_a, ack_a);
    else passed++;
    reti = 1'b1; tick(); reti = 1'b0;
    checks++;
    if (ad_a !== 8'h07 || isr_a !== 1'b0 || ad_b !== 8'h07 || err_a !== 1'b0)
      $display("FAIL disp_reti got ad %h/%h isr %b err %b exp 07 0 0", ad_a, ad_b, isr_a, err_a);
    else passed++;
  endtask

  task automatic test_preempt();
    ev = 4'h0; ien = 1'b1; set_vecs(8'h40, 8'h00, 8'h60, 8'h70);
    do_reset(1);
    tick();
    ev = 4'b0100; tick(); tick();
    checks++;
    if (ad_a !== 8'h60 || act_a !== 2'd2 || ack_a !== 4'b0100)
      $display("FAIL pre_ch2 got ad %h act %0d ack %b exp 60 2 0100", ad_a, act_a, ack_a);
    else passed++;
    ev = 4'b1101; tick(); tick();
    checks++;
    if (ad_a !== 8'h40 || act_a !== 2'd0 || ack_a !== 4'b0001 || pend_a !== 4'b1000)
      $display("FAIL pre_ch0 got ad %h act %0d ack %b pend %b exp 40 0 0001 1000", ad_a, act_a, ack_a, pend_a);
    else passed++;
    tick();
    reti = 1'b1; tick(); reti = 1'b0;
    checks++;
    if (ad_a !== 8'h62 || act_a !== 2'd2 || isr_a !== 1'b1 || pend_a !== 4'b1000)
      $display("FAIL pre_ret1 got ad %h act %0d isr %b pend %b exp 62 2 1 1000", ad_a, act_a, isr_a, pend_a);
    else passed++;
    tick();
    checks++;
    if (ad_a !== 8'h63 || ack_a !== 4'h0)
      $display("FAIL pre_lowwait got ad %h ack %b exp 63 0000", ad_a, ack_a);
    else passed++;
    reti = 1'b1; tick(); reti = 1'b0;
    checks++;
    if (ad_a !== 8'h03 || isr_a !== 1'b0 || pend_a !== 4'b1000 || ack_a !== 4'h0)
      $display("FAIL pre_ret2 got ad %h isr %b pend %b ack %b exp 03 0 1000 0000", ad_a, isr_a, pend_a, ack_a);
    else passed++;
    tick();
    checks++;
    if (ad_a !== 8'h70 || ack_a !== 4'b1000 || act_a !== 2'd3 || pend_a !== 4'h0)
      $display("FAIL pre_ch3 got ad %h ack %b act %0d pend %b exp 70 1000 3 0000", ad_a, ack_a, act_a, pend_a);
    else passed++;
  endtask

  task automatic test_stack_full();
    ev = 4'h0; ien = 1'b1; set_vecs(8'h40, 8'h20, 8'h00, 8'h00);
    do_reset(1);
    tick();
    ev = 4'b0010; tick(); tick();
    checks++;
    if (ad_b !== 8'h20 || act_b !== 2'd1 || isr_b !== 1'b1)
      $display("FAIL full_ch1 got ad %h act %0d isr %b exp 20 1 1", ad_b, act_b, isr_b);
    else passed++;
    ev = 4'b0011; tick(); tick();
    checks++;
    if (ad_b !== 8'h22 || pend_b !== 4'b0001 || ack_b !== 4'h0 || ad_a !== 8'h40 || ack_a !== 4'b0001)
      $display("FAIL full_block got b ad %h pend %b ack %b a ad %h ack %b exp 22 0001 0000 40 0001",
               ad_b, pend_b, ack_b, ad_a, ack_a);
    else passed++;
    reti = 1'b1; tick(); reti = 1'b0;
    checks++;
    if (ad_b !== 8'h03 || isr_b !== 1'b0 || pend_b !== 4'b0001)
      $display("FAIL full_ret got ad %h isr %b pend %b exp 03 0 0001", ad_b, isr_b, pend_b);
    else passed++;
    tick();
    checks++;
    if (ad_b !== 8'h40 || ack_b !== 4'b0001 || act_b !== 2'd0 || isr_b !== 1'b1)
      $display("FAIL full_late got ad %h ack %b act %0d isr %b exp 40 0001 0 1", ad_b, ack_b, act_b, isr_b);
    else passed++;
  endtask

  task automatic test_disabled_vec();
    ev = 4'h0; ien = 1'b1; set_vecs(8'h00, 8'h00, 8'h00, 8'h00);
    do_reset(1);
    tick();
    ev = 4'b0010; tick(); tick(); tick();
    checks++;
    if (ad_a !== 8'h04 || pend_a !== 4'b0010 || ack_a !== 4'h0)
      $display("FAIL dis_hold got ad %h pend %b ack %b exp 04 0010 0000", ad_a, pend_a, ack_a);
    else passed++;
    vecs[1] = 8'h20; tick();
    checks++;
    if (ad_a !== 8'h20 || ack_a !== 4'b0010 || pend_a !== 4'h0)
      $display("FAIL dis_enable got ad %h ack %b pend %b exp 20 0010 0000", ad_a, ack_a, pend_a);
    else passed++;
    reti = 1'b1; tick();
    checks++;
    if (ad_a !== 8'h05 || err_a !== 1'b0)
      $display("FAIL dis_ret got ad %h err %b exp 05 0", ad_a, err_a);
    else passed++;
    tick(); reti = 1'b0;
    checks++;
    if (ad_a !== 8'h06 || err_a !== 1'b1 || isr_a !== 1'b0)
      $display("FAIL stk_err got ad %h err %b isr %b exp 06 1 0", ad_a, err_a, isr_a);
    else passed++;
    tick();
    checks++;
    if (ad_a !== 8'h07 || err_a !== 1'b1)
      $display("FAIL stk_err_sticky got ad %h err %b exp 07 1", ad_a, err_a);
    else passed++;
  endtask

  task automatic test_reset_events();
    ien = 1'b1; set_vecs(8'h00, 8'h00, 8'h00, 8'h00);
    ev = 4'b0001;
    do_reset(2);
    tick();
    checks++;
    if (pend_a !== 4'h0 || ad_a !== 8'h01)
      $display("FAIL rst_level got pend %b ad %h exp 0000 01", pend_a, ad_a);
    else passed++;
    vecs[0] = 8'h40;
    ev = 4'b0000; tick();
    ev = 4'b0001; tick(); tick();
    checks++;
    if (ad_a !== 8'h40 || isr_a !== 1'b1)
      $display("FAIL rst_enter got ad %h isr %b exp 40 1", ad_a, isr_a);
    else passed++;
    ev = 4'b1111;
    do_reset(1);
    checks++;
    if (ad_a !== 8'h00 || isr_a !== 1'b0 || pend_a !== 4'h0 || act_a !== 2'd0 || ack_a !== 4'h0)
      $display("FAIL rst_mid got ad %h isr %b pend %b act %0d exp 00 0 0000 0", ad_a, isr_a, pend_a, act_a);
    else passed++;
    tick();
    checks++;
    if (ad_a !== 8'h01 || pend_a !== 4'h0)
      $display("FAIL rst_after got ad %h pend %b exp 01 0000", ad_a, pend_a);
    else passed++;
  endtask

  task automatic test_random();
    ev = 4'h0; ld = 1'b0; reti = 1'b0; ien = 1'b1;
    set_vecs(8'h40, 8'h20, 8'h60, 8'h70);
    do_reset(1);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) ev[$urandom_range(0, 3)] ^= 1'b1;
      ld    = ($urandom_range(0, 5) == 0);
      adr   = 8'($urandom);
      reti  = ($urandom_range(0, 6) == 0);
      ien   = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 29) == 0)
        vecs[$urandom_range(0, 3)] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs(m) !== expv(m))
          $display("FAIL rand cyc=%0d dut%0d got %h exp %h", c, m, obs(m), expv(m));
        else passed++;
      end
    end
    rst_n = 1'b1; ld = 1'b0; reti = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ld = 1'b0; ien = 1'b0; reti = 1'b0; adr = 8'h00; ev = 4'h0;
    set_vecs(8'h00, 8'h00, 8'h00, 8'h00);
    m_lim[0] = 4;
    m_lim[1] = 1;
    test_reset();
    test_wrap();
    test_dispatch();
    test_preempt();
    test_stack_full();
    test_disabled_vec();
    test_reset_events();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
